// File: rtl/seven_segment_pkg.sv
// Shared definitions for the seven-segment display path.
// Glyph codes are active-low {g,f,e,d,c,b,a}.
package seven_segment_pkg;

    localparam logic [6:0] GLYPH_0 = 7'b1000000;
    localparam logic [6:0] GLYPH_1 = 7'b1111001;
    localparam logic [6:0] GLYPH_2 = 7'b0100100;
    localparam logic [6:0] GLYPH_3 = 7'b0110000;
    localparam logic [6:0] GLYPH_4 = 7'b0011001;
    localparam logic [6:0] GLYPH_5 = 7'b0010010;
    localparam logic [6:0] GLYPH_6 = 7'b0000010;
    localparam logic [6:0] GLYPH_7 = 7'b1111000;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0010000;

    localparam logic [3:0] BCD_INVALID = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        DWELL,
        HELD
    } cap_state_t;

endpackage

// File: rtl/seven_segment_glyph_decode.sv
// Combinational glyph-to-BCD decoder.
// Unknown glyphs report valid=0 with bcd=BCD_INVALID.
module seven_segment_glyph_decode
    import seven_segment_pkg::*;
(
    input  logic [6:0] seg,
    output logic       valid,
    output logic [3:0] bcd
);

    // Table lookup; anything outside the ten digits is invalid
    always_comb begin
        valid = 1'b1;
        bcd   = BCD_INVALID;
        case (seg)
            GLYPH_0: bcd = 4'd0;
            GLYPH_1: bcd = 4'd1;
            GLYPH_2: bcd = 4'd2;
            GLYPH_3: bcd = 4'd3;
            GLYPH_4: bcd = 4'd4;
            GLYPH_5: bcd = 4'd5;
            GLYPH_6: bcd = 4'd6;
            GLYPH_7: bcd = 4'd7;
            GLYPH_8: bcd = 4'd8;
            GLYPH_9: bcd = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_segment_capture.sv
// Receive side of the multiplexed 4-digit display: samples
// the scanned buses and rebuilds the 16-bit BCD number.
module seven_segment_capture
    import seven_segment_pkg::*;
#(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  an_in,
    output logic [15:0] number,
    output logic        frame_valid,
    output logic        seg_err,
    output logic        an_err,
    output logic        stalled
);

    localparam int DW = $clog2(STABLE_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TIME_LAST  = TW'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0][6:0] seg_pipe;
    logic [SYNC_STAGES-1:0][3:0] an_pipe;
    logic [6:0]        seg_s;
    logic [3:0]        an_s;
    logic [10:0]       bus_q;
    logic              change;
    logic              idx_ok;
    logic              an_ill;
    logic [1:0]        idx;
    logic [3:0]        oh;
    logic [DW-1:0]     dcnt;
    logic [TW-1:0]     tcnt;
    cap_state_t        state;
    logic              cap;
    logic              g_valid;
    logic [3:0]        g_bcd;
    logic [3:0]        nib;
    logic [3:0][3:0]   shadow;
    logic [3:0][3:0]   merged;
    logic [3:0]        seen;

    // Synchronisers idle at the blank bus (all lines high)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_pipe <= '1;
            an_pipe  <= '1;
        end else begin
            seg_pipe <= {seg_pipe[SYNC_STAGES-2:0], seg_in};
            an_pipe  <= {an_pipe[SYNC_STAGES-2:0], an_in};
        end
    end

    assign seg_s  = seg_pipe[SYNC_STAGES-1];
    assign an_s   = an_pipe[SYNC_STAGES-1];
    assign change = ({an_s, seg_s} != bus_q);

    // Previous synced bus, used to detect any change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_q <= '1;
        end else begin
            bus_q <= {an_s, seg_s};
        end
    end

    // Anode decode: one low bit selects a digit, else blank
    always_comb begin
        idx_ok = 1'b0;
        an_ill = 1'b0;
        idx    = 2'd0;
        unique case (an_s)
            4'b1110: begin idx_ok = 1'b1; idx = 2'd0; end
            4'b1101: begin idx_ok = 1'b1; idx = 2'd1; end
            4'b1011: begin idx_ok = 1'b1; idx = 2'd2; end
            4'b0111: begin idx_ok = 1'b1; idx = 2'd3; end
            4'b1111: ;
            default: an_ill = 1'b1;
        endcase
    end

    assign oh = 4'b0001 << idx;

    seven_segment_glyph_decode u_dec (
        .seg   (seg_s),
        .valid (g_valid),
        .bcd   (g_bcd)
    );

    assign nib = g_valid ? g_bcd : BCD_INVALID;

    // Dwell counter restarts on every bus change and saturates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt <= '0;
        end else if (change) begin
            dcnt <= '0;
        end else if (dcnt != DWELL_LAST) begin
            dcnt <= dcnt + 1'b1;
        end
    end

    assign cap = (state == DWELL) && !change
              && (dcnt == DWELL_LAST);

    // Dwell FSM: one capture per stable dwell
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (change) begin
            state <= idx_ok ? DWELL : IDLE;
        end else begin
            unique case (state)
                IDLE:    if (idx_ok) state <= DWELL;
                DWELL:   if (cap) state <= HELD;
                HELD:    state <= HELD;
                default: state <= IDLE;
            endcase
        end
    end

    // Shadow with the capturing nibble already merged in
    always_comb begin
        merged      = shadow;
        merged[idx] = nib;
    end

    // Capture, frame assembly and stall timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            number      <= '0;
            frame_valid <= 1'b0;
            seg_err     <= 1'b0;
            an_err      <= 1'b0;
            stalled     <= 1'b0;
            shadow      <= '0;
            seen        <= '0;
            tcnt        <= '0;
        end else begin
            frame_valid <= 1'b0;
            seg_err     <= 1'b0;
            an_err      <= an_ill;
            if (cap) begin
                shadow[idx] <= nib;
                seg_err     <= !g_valid;
                stalled     <= 1'b0;
                tcnt        <= '0;
                if ((seen | oh) == 4'b1111) begin
                    number      <= merged;
                    frame_valid <= 1'b1;
                    seen        <= '0;
                end else begin
                    seen <= seen | oh;
                end
            end else if (tcnt == TIME_LAST) begin
                stalled <= 1'b1;
                seen    <= '0;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Scoreboard bench for seven_segment_capture.
// Expected frames are queued as scans are driven.
module tb_seven_segment_capture;

    localparam int STABLE  = 16;
    localparam int TIMEOUT = 2000;
    localparam int SYNC    = 2;
    localparam int DWELLN  = 100;

    logic        clk;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic [3:0]  an_in;
    logic [15:0] number;
    logic        frame_valid;
    logic        seg_err;
    logic        an_err;
    logic        stalled;

    int checks;
    int errors;
    int frames;
    int seg_errs;
    logic [15:0] sb[$];

    seven_segment_capture #(
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TIMEOUT),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .number      (number),
        .frame_valid (frame_valid),
        .seg_err     (seg_err),
        .an_err      (an_err),
        .stalled     (stalled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0: enc = 7'b1000000;
            4'd1: enc = 7'b1111001;
            4'd2: enc = 7'b0100100;
            4'd3: enc = 7'b0110000;
            4'd4: enc = 7'b0011001;
            4'd5: enc = 7'b0010010;
            4'd6: enc = 7'b0000010;
            4'd7: enc = 7'b1111000;
            4'd8: enc = 7'b0000000;
            4'd9: enc = 7'b0010000;
            default: enc = 7'b1111111;
        endcase
    endfunction

    // Scoreboard: every frame_valid pops one expected number
    always @(negedge clk) begin
        if (rst_n && frame_valid) begin
            frames++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_frame: number=%h", number);
            end else begin
                logic [15:0] e;
                e = sb.pop_front();
                if (number !== e) begin
                    errors++;
                    $display("FAIL frame_number: got %h want %h",
                             number, e);
                end
            end
        end
        if (rst_n && seg_err) seg_errs++;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_digit(input int i, input logic [6:0] g,
                               input int n);
        an_in  = ~(4'b0001 << i);
        seg_in = g;
        cycles(n);
    endtask

    task automatic blank(input int n);
        an_in  = 4'b1111;
        seg_in = 7'b1111111;
        cycles(n);
    endtask

    task automatic scan(input logic [15:0] v);
        for (int i = 0; i < 4; i++)
            drive_digit(i, enc(v[4*i +: 4]), DWELLN);
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d frames missing, want 0",
                     name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        an_in  = 4'b1111;
        seg_in = 7'b1111111;
        cycles(4);
        checks++;
        if ({number, frame_valid, seg_err, an_err, stalled} !== 20'h0)
        begin
            errors++;
            $display("FAIL reset_outputs: got %h/%b%b%b%b want 0",
                     number, frame_valid, seg_err, an_err, stalled);
        end
        rst_n = 1'b1;
        cycles(3);
    endtask

    task automatic test_scan_1234();
        int f0, s0;
        f0 = frames;
        s0 = seg_errs;
        sb.push_back(16'h1234);
        scan(16'h1234);
        sb.push_back(16'h1234);
        scan(16'h1234);
        blank(5);
        check_drained("scan_1234_drain");
        checks++;
        if (frames - f0 != 2) begin
            errors++;
            $display("FAIL scan_1234_frames: got %0d want 2",
                     frames - f0);
        end
        checks++;
        if (seg_errs != s0) begin
            errors++;
            $display("FAIL scan_1234_seg_err: got %0d want 0",
                     seg_errs - s0);
        end
        checks++;
        if (number !== 16'h1234) begin
            errors++;
            $display("FAIL scan_1234_number: got %h want 1234",
                     number);
        end
    endtask

    task automatic test_glitch();
        sb.push_back(16'h1234);
        drive_digit(0, enc(4'd4), DWELLN);
        drive_digit(1, enc(4'd3), DWELLN);
        drive_digit(1, enc(4'd7), 10);
        drive_digit(2, enc(4'd2), DWELLN);
        drive_digit(3, enc(4'd1), DWELLN);
        blank(5);
        check_drained("glitch_drain");
        checks++;
        if (number !== 16'h1234) begin
            errors++;
            $display("FAIL glitch_number: got %h want 1234", number);
        end
    endtask

    task automatic test_seg_err();
        int s0;
        s0 = seg_errs;
        sb.push_back(16'h5F78);
        drive_digit(0, enc(4'd8), DWELLN);
        drive_digit(1, enc(4'd7), DWELLN);
        drive_digit(2, 7'b1111110, DWELLN);
        drive_digit(3, enc(4'd5), DWELLN);
        blank(5);
        check_drained("seg_err_drain");
        checks++;
        if (seg_errs - s0 != 1) begin
            errors++;
            $display("FAIL seg_err_pulses: got %0d want 1",
                     seg_errs - s0);
        end
    endtask

    task automatic test_an_err();
        int f0, bad;
        f0 = frames;
        bad = 0;
        an_in  = 4'b1100;
        seg_in = enc(4'd3);
        for (int k = 0; k < DWELLN; k++) begin
            @(negedge clk);
            if (k >= 4 && an_err !== 1'b1) bad++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL an_err_high: %0d low cycles want 0", bad);
        end
        blank(6);
        checks++;
        if (an_err !== 1'b0) begin
            errors++;
            $display("FAIL an_err_clear: got %b want 0", an_err);
        end
        checks++;
        if (frames != f0 || number !== 16'h5F78) begin
            errors++;
            $display("FAIL an_err_nocap: frames+%0d num %h want 0 5f78",
                     frames - f0, number);
        end
        sb.push_back(16'h1357);
        scan(16'h1357);
        blank(5);
        check_drained("an_err_rescan_drain");
    endtask

    task automatic test_timeout();
        int hit;
        drive_digit(0, enc(4'd9), DWELLN);
        drive_digit(1, enc(4'd9), DWELLN);
        blank(1500);
        checks++;
        if (stalled !== 1'b0) begin
            errors++;
            $display("FAIL stall_early: got %b want 0", stalled);
        end
        hit = 0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (stalled === 1'b1) begin
                hit = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (hit != 1) begin
            errors++;
            $display("FAIL stall_set: got %0d want 1", hit);
        end
        checks++;
        if (number !== 16'h1357) begin
            errors++;
            $display("FAIL stall_hold: got %h want 1357", number);
        end
        drive_digit(2, enc(4'd0), DWELLN);
        checks++;
        if (stalled !== 1'b0) begin
            errors++;
            $display("FAIL stall_clear: got %b want 0", stalled);
        end
        drive_digit(3, enc(4'd9), DWELLN);
        sb.push_back(16'h9012);
        drive_digit(0, enc(4'd2), DWELLN);
        drive_digit(1, enc(4'd1), DWELLN);
        blank(5);
        check_drained("stall_rescan_drain");
    endtask

    task automatic test_latency();
        int n, found;
        drive_digit(0, enc(4'd8), DWELLN);
        drive_digit(1, enc(4'd6), DWELLN);
        drive_digit(2, enc(4'd4), DWELLN);
        sb.push_back(16'h2468);
        an_in  = 4'b0111;
        seg_in = enc(4'd2);
        n = 0;
        found = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (frame_valid === 1'b1) begin
                found = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (found != 1 || n != STABLE + 1 + SYNC) begin
            errors++;
            $display("FAIL latency: got %0d (found %0d) want %0d",
                     n, found, STABLE + 1 + SYNC);
        end
        blank(5);
        check_drained("latency_drain");
    endtask

    task automatic test_reset_midframe();
        drive_digit(0, enc(4'd1), DWELLN);
        drive_digit(1, enc(4'd1), DWELLN);
        drive_digit(2, enc(4'd1), DWELLN);
        rst_n = 1'b0;
        cycles(3);
        checks++;
        if (number !== 16'h0 || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_number: got %h/%b want 0/0",
                     number, frame_valid);
        end
        an_in  = 4'b1111;
        seg_in = 7'b1111111;
        cycles(2);
        rst_n = 1'b1;
        cycles(3);
        sb.delete();
        sb.push_back(16'h0042);
        scan(16'h0042);
        blank(5);
        check_drained("midreset_drain");
        checks++;
        if (number !== 16'h0042) begin
            errors++;
            $display("FAIL midreset_rescan: got %h want 0042", number);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        frames   = 0;
        seg_errs = 0;
        rst_n    = 1'b0;
        an_in    = 4'b1111;
        seg_in   = 7'b1111111;
        @(posedge clk);
        #1;
        test_reset();
        test_scan_1234();
        test_glitch();
        test_seg_err();
        test_an_err();
        test_timeout();
        test_latency();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
